// File: rtl/usb_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_buf_pkg
// Description : Shared constants and status type for the USB endpoint buffer
//               and the AHB-lite status register that reports on it.
// Revision    : 1.0 - initial packet-aware buffer release
// ============================================================================
package usb_buf_pkg;

   localparam int BUF_DATA_W = 8;
   localparam int BUF_DEPTH  = 64;
   localparam int BUF_AFULL  = 56;

   // Bit order matches the AHB status register layout, MSB first.
   typedef struct packed {
      logic empty;
      logic full;
      logic almost_full;
      logic overflow;
      logic underflow;
   } buf_status_t;

endpackage : usb_buf_pkg
`default_nettype wire

// File: rtl/packet_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : packet_fifo_mem
// Description : DEPTH x DATA_W register array, one synchronous write port and
//               one asynchronous (show-ahead) read port. Contents not reset.
// Revision    : 1.0 - initial packet-aware buffer release
// ============================================================================
module packet_fifo_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 64,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Store one word per accepted write.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = r_mem[raddr];

endmodule : packet_fifo_mem
`default_nettype wire

// File: rtl/packet_fifo_buffer.sv
`default_nettype none
// ============================================================================
// Module      : packet_fifo_buffer
// Description : Synchronous FIFO with packet commit/discard. Words written
//               by the receive side stay hidden behind cmt_ptr until commit;
//               discard rewinds the write pointer to the last commit point.
// Revision    : 1.0 - initial packet-aware buffer release
// ============================================================================
module packet_fifo_buffer
   import usb_buf_pkg::*;
#(
   parameter int DATA_W       = BUF_DATA_W,
   parameter int DEPTH        = BUF_DEPTH,
   parameter int AFULL_THRESH = BUF_AFULL
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     commit,
   input  logic                     discard,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        rd_data,
   input  logic                     flush,
   input  logic                     clear,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [$clog2(DEPTH):0]   pending,
   output logic                     empty,
   output logic                     full,
   output logic                     almost_full,
   output logic                     overflow,
   output logic                     underflow
);

   // Pointers carry one extra MSB so a full buffer is distinguishable from
   // an empty one; all arithmetic wraps modulo 2^PW.
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] c_PTR_ONE  = PW'(1);
   localparam logic [PW-1:0] c_FILL_MAX = PW'(DEPTH);
   localparam logic [PW-1:0] c_FILL_AF  = PW'(AFULL_THRESH);

   logic [PW-1:0]     r_rd_ptr;
   logic [PW-1:0]     r_cmt_ptr;
   logic [PW-1:0]     r_wr_ptr;
   logic              r_overflow;
   logic              r_underflow;

   logic [PW-1:0]     w_occ;
   logic [PW-1:0]     w_pend;
   logic [PW-1:0]     w_fill;
   logic              w_empty;
   logic              w_full;
   logic              w_idle;
   logic              w_wr_accept;
   logic              w_rd_accept;
   logic [PW-1:0]     w_wr_next;
   logic [DATA_W-1:0] w_mem_rdata;
   buf_status_t       w_status;

   assign w_occ   = r_cmt_ptr - r_rd_ptr;
   assign w_pend  = r_wr_ptr - r_cmt_ptr;
   assign w_fill  = w_occ + w_pend;
   assign w_empty = (w_occ == '0);
   // Full looks only at registered state; a same-cycle pop frees nothing.
   assign w_full  = (w_fill == c_FILL_MAX);

   // clear/flush swallow every other request issued in the same cycle.
   assign w_idle      = clear | flush;
   // A discarded write never reaches memory and raises no overflow.
   assign w_wr_accept = wr_en & ~w_full & ~w_idle & ~discard;
   assign w_rd_accept = rd_en & ~w_empty & ~w_idle;
   assign w_wr_next   = w_wr_accept ? (r_wr_ptr + c_PTR_ONE) : r_wr_ptr;

   // Pointer and sticky-flag update: rst > clear > flush > normal operation.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_rd_ptr    <= '0;
         r_cmt_ptr   <= '0;
         r_wr_ptr    <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (flush) begin
         r_rd_ptr    <= '0;
         r_cmt_ptr   <= '0;
         r_wr_ptr    <= '0;
      end else begin
         if (discard) begin
            r_wr_ptr <= r_cmt_ptr;
         end else begin
            r_wr_ptr <= w_wr_next;
            if (commit) begin
               r_cmt_ptr <= w_wr_next;
            end
         end
         if (w_rd_accept) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         if (wr_en && w_full && !discard) begin
            r_overflow <= 1'b1;
         end
         if (rd_en && w_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   packet_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk    (clk),
      .we     (w_wr_accept),
      .waddr  (r_wr_ptr[AW-1:0]),
      .wdata  (wr_data),
      .raddr  (r_rd_ptr[AW-1:0]),
      .rdata  (w_mem_rdata)
   );

   assign w_status.empty       = w_empty;
   assign w_status.full        = w_full;
   assign w_status.almost_full = (w_fill >= c_FILL_AF);
   assign w_status.overflow    = r_overflow;
   assign w_status.underflow   = r_underflow;

   // Uninitialised memory must never leak out while nothing is committed.
   assign rd_data     = w_empty ? '0 : w_mem_rdata;
   assign occupancy   = w_occ;
   assign pending     = w_pend;
   assign empty       = w_status.empty;
   assign full        = w_status.full;
   assign almost_full = w_status.almost_full;
   assign overflow    = w_status.overflow;
   assign underflow   = w_status.underflow;

endmodule : packet_fifo_buffer
`default_nettype wire

// File: tb/tb_packet_fifo_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_packet_fifo_buffer
// Description : Directed self-checking bench for packet_fifo_buffer.
// Revision    : 1.0 - initial packet-aware buffer release
// ============================================================================
module tb_packet_fifo_buffer;

   logic       tb_clk = 1'b0;
   logic       rst = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       commit = 1'b0;
   logic       discard = 1'b0;
   logic       rd_en = 1'b0;
   logic       flush = 1'b0;
   logic       clear = 1'b0;
   logic [7:0] rd_data;
   logic [6:0] occupancy;
   logic [6:0] pending;
   logic       empty;
   logic       full;
   logic       almost_full;
   logic       overflow;
   logic       underflow;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 tb_clk = ~tb_clk;

   packet_fifo_buffer #(
      .DATA_W       (8),
      .DEPTH        (64),
      .AFULL_THRESH (56)
   ) dut (
      .clk         (tb_clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .commit      (commit),
      .discard     (discard),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .flush       (flush),
      .clear       (clear),
      .occupancy   (occupancy),
      .pending     (pending),
      .empty       (empty),
      .full        (full),
      .almost_full (almost_full),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   // One clock edge; inputs are then released and outputs sampled 1 ns later.
   task automatic step();
      @(posedge tb_clk);
      #1;
      rst = 0; wr_en = 0; commit = 0; discard = 0; rd_en = 0; flush = 0; clear = 0;
   endtask

   task automatic push(input logic [7:0] d, input logic c);
      wr_en = 1; wr_data = d; commit = c;
      step();
   endtask

   task automatic test_reset();
      rst = 1;
      step();
      n_checks++; if (occupancy !== 7'd0) begin n_fail++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
      n_checks++; if (pending !== 7'd0) begin n_fail++; $display("FAIL reset_pend: got %0d expected 0", pending); end
      n_checks++; if ({empty, full, almost_full, overflow, underflow} !== 5'b10000) begin n_fail++; $display("FAIL reset_flags: got %b expected 10000", {empty, full, almost_full, overflow, underflow}); end
      n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data); end
   endtask

   task automatic test_fill_commit();
      for (int i = 0; i < 64; i++) begin
         push(8'(i), 1'b0);
         n_checks++; if (pending !== 7'(i + 1)) begin n_fail++; $display("FAIL fill_pend[%0d]: got %0d expected %0d", i, pending, i + 1); end
         n_checks++; if (occupancy !== 7'd0) begin n_fail++; $display("FAIL fill_occ[%0d]: got %0d expected 0", i, occupancy); end
      end
      commit = 1;
      step();
      n_checks++; if (occupancy !== 7'd64) begin n_fail++; $display("FAIL commit_occ: got %0d expected 64", occupancy); end
      n_checks++; if (pending !== 7'd0) begin n_fail++; $display("FAIL commit_pend: got %0d expected 0", pending); end
      n_checks++; if ({full, almost_full, empty} !== 3'b110) begin n_fail++; $display("FAIL commit_flags: got %b expected 110", {full, almost_full, empty}); end
      n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL commit_rd_data: got %0h expected 0", rd_data); end
   endtask

   task automatic test_drain();
      for (int i = 0; i < 64; i++) begin
         rd_en = 1;
         step();
         n_checks++; if (rd_data !== ((i < 63) ? 8'(i + 1) : 8'h00)) begin n_fail++; $display("FAIL drain_data[%0d]: got %0h expected %0h", i, rd_data, (i < 63) ? i + 1 : 0); end
         n_checks++; if (occupancy !== 7'(63 - i)) begin n_fail++; $display("FAIL drain_occ[%0d]: got %0d expected %0d", i, occupancy, 63 - i); end
      end
      n_checks++; if ({empty, underflow} !== 2'b10) begin n_fail++; $display("FAIL drain_end: got empty/underflow %b expected 10", {empty, underflow}); end
      rd_en = 1;
      step();
      n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_set: got %b expected 1", underflow); end
      n_checks++; if (occupancy !== 7'd0) begin n_fail++; $display("FAIL underflow_occ: got %0d expected 0", occupancy); end
   endtask

   task automatic test_discard();
      for (int i = 0; i < 10; i++) push(8'hA0 + 8'(i), 1'b0);
      n_checks++; if (pending !== 7'd10) begin n_fail++; $display("FAIL discard_pre_pend: got %0d expected 10", pending); end
      wr_en = 1; wr_data = 8'hAA; discard = 1;
      step();
      n_checks++; if ({pending, occupancy} !== 14'd0) begin n_fail++; $display("FAIL discard_counts: got pend %0d occ %0d expected 0 0", pending, occupancy); end
      n_checks++; if ({empty, overflow} !== 2'b10) begin n_fail++; $display("FAIL discard_flags: got empty/overflow %b expected 10", {empty, overflow}); end
      push(8'h11, 1'b0);
      push(8'h12, 1'b0);
      push(8'h13, 1'b1);
      n_checks++; if (occupancy !== 7'd3) begin n_fail++; $display("FAIL discard_recommit_occ: got %0d expected 3", occupancy); end
      n_checks++; if (rd_data !== 8'h11) begin n_fail++; $display("FAIL discard_recommit_data: got %0h expected 11", rd_data); end
   endtask

   task automatic test_overflow_flush_clear();
      flush = 1;
      step();
      n_checks++; if ({occupancy, underflow} !== {7'd0, 1'b1}) begin n_fail++; $display("FAIL flush_keeps_underflow: got occ %0d underflow %b expected 0 1", occupancy, underflow); end
      for (int i = 0; i < 64; i++) push(8'(i) ^ 8'h5A, i == 63);
      n_checks++; if ({occupancy, overflow} !== {7'd64, 1'b0}) begin n_fail++; $display("FAIL ovf_pre: got occ %0d overflow %b expected 64 0", occupancy, overflow); end
      push(8'h55, 1'b0);
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
      n_checks++; if ({occupancy, pending} !== {7'd64, 7'd0}) begin n_fail++; $display("FAIL ovf_counts: got occ %0d pend %0d expected 64 0", occupancy, pending); end
      n_checks++; if (rd_data !== 8'h5A) begin n_fail++; $display("FAIL ovf_head: got %0h expected 5a", rd_data); end
      flush = 1; wr_en = 1; rd_en = 1;
      step();
      n_checks++; if ({occupancy, pending} !== 14'd0) begin n_fail++; $display("FAIL flush_counts: got occ %0d pend %0d expected 0 0", occupancy, pending); end
      n_checks++; if ({overflow, underflow, rd_data} !== {2'b11, 8'h00}) begin n_fail++; $display("FAIL flush_flags: got ovf %b udf %b data %0h expected 1 1 0", overflow, underflow, rd_data); end
      clear = 1;
      step();
      n_checks++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL clear_flags: got %b expected 00", {overflow, underflow}); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 40; i++) push(8'(i), i == 39);
      for (int i = 0; i < 40; i++) begin
         n_checks++; if (rd_data !== 8'(i)) begin n_fail++; $display("FAIL wrap_first[%0d]: got %0h expected %0h", i, rd_data, i); end
         rd_en = 1;
         step();
      end
      for (int i = 0; i < 40; i++) push(8'h80 + 8'(i), i == 39);
      for (int i = 0; i < 40; i++) begin
         n_checks++; if ({occupancy, rd_data} !== {7'(40 - i), 8'h80 + 8'(i)}) begin n_fail++; $display("FAIL wrap_second[%0d]: got occ %0d data %0h expected %0d %0h", i, occupancy, rd_data, 40 - i, 8'h80 + i); end
         rd_en = 1;
         step();
      end
      n_checks++; if ({empty, occupancy} !== {1'b1, 7'd0}) begin n_fail++; $display("FAIL wrap_end: got empty %b occ %0d expected 1 0", empty, occupancy); end
   endtask

   task automatic test_back_to_back();
      clear = 1;
      step();
      push(8'h31, 1'b0);
      push(8'h32, 1'b0);
      push(8'h33, 1'b1);
      push(8'h34, 1'b0);
      push(8'h35, 1'b0);
      wr_en = 1; wr_data = 8'h36; commit = 1; rd_en = 1;
      step();
      n_checks++; if ({occupancy, pending} !== {7'd5, 7'd0}) begin n_fail++; $display("FAIL b2b_counts: got occ %0d pend %0d expected 5 0", occupancy, pending); end
      n_checks++; if (rd_data !== 8'h32) begin n_fail++; $display("FAIL b2b_head: got %0h expected 32", rd_data); end
   endtask

   task automatic test_rst_midpacket();
      clear = 1;
      step();
      for (int i = 0; i < 20; i++) push(8'hC0 + 8'(i), i == 19);
      for (int i = 0; i < 5; i++) push(8'hE0 + 8'(i), 1'b0);
      n_checks++; if ({occupancy, pending} !== {7'd20, 7'd5}) begin n_fail++; $display("FAIL mid_pre: got occ %0d pend %0d expected 20 5", occupancy, pending); end
      rst = 1;
      step();
      n_checks++; if ({occupancy, pending, rd_data} !== 22'd0) begin n_fail++; $display("FAIL mid_rst_counts: got occ %0d pend %0d data %0h expected 0 0 0", occupancy, pending, rd_data); end
      n_checks++; if ({empty, full, almost_full, overflow, underflow} !== 5'b10000) begin n_fail++; $display("FAIL mid_rst_flags: got %b expected 10000", {empty, full, almost_full, overflow, underflow}); end
   endtask

   task automatic test_almost_full();
      for (int i = 0; i < 55; i++) push(8'(i), 1'b0);
      n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL afull_55: got %b expected 0", almost_full); end
      push(8'hFF, 1'b0);
      n_checks++; if ({almost_full, full} !== 2'b10) begin n_fail++; $display("FAIL afull_56: got af/full %b expected 10", {almost_full, full}); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_fill_commit();
      test_drain();
      test_discard();
      test_overflow_flush_clear();
      test_wrap();
      test_back_to_back();
      test_rst_midpacket();
      test_almost_full();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_packet_fifo_buffer
`default_nettype wire

// File: doc/packet_fifo_buffer.md
Name: packet_fifo_buffer

Overview:
Parametrised successor to the USB endpoint data buffer. It is a synchronous FIFO of DEPTH words, each DATA_W bits wide, with packet-level commit/discard: bytes written by the receive side stay invisible to the reader until the packet is committed, and a bad packet (CRC or PID error) can be rolled back. It sits between the USB RX/TX controllers and the AHB-lite slave, and replaces the fixed 64x8 buffer. It adds almost-full, sticky overflow/underflow flags and a pending-byte count.

Parameters:
DATA_W, 8, width of each stored word
DEPTH, 64, number of entries; power of two, at least 4
AFULL_THRESH, 56, total-fill level (committed plus pending) at or above which almost_full asserts; must be at most DEPTH

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-high; the single clock is clk
wr_en  in  1  write wr_data at the speculative write pointer
wr_data  in  DATA_W  write data
commit  in  1  make all pending words (including a same-cycle write) visible to the reader
discard  in  1  drop all pending words (including a same-cycle write)
rd_en  in  1  pop the head word
rd_data  out  DATA_W  head of committed data (show-ahead)
flush  in  1  drop all data; sticky flags kept
clear  in  1  drop all data and clear sticky flags
occupancy  out  $clog2(DEPTH)+1  committed words available to the reader
pending  out  $clog2(DEPTH)+1  written but uncommitted words
empty  out  1  occupancy == 0
full  out  1  occupancy + pending == DEPTH
almost_full  out  1  occupancy + pending >= AFULL_THRESH
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- State registers: rd_ptr, cmt_ptr, wr_ptr, each $clog2(DEPTH)+1 bits wide with natural wrap; the MSB distinguishes full from empty. occupancy = cmt_ptr - rd_ptr. pending = wr_ptr - cmt_ptr. Subtractions are modulo 2^(ptr width).
- Reset (rst=1 at a clk edge): all pointers 0, overflow=0, underflow=0. Therefore occupancy=0, pending=0, empty=1, full=0, almost_full=0, rd_data=0. Memory contents are not reset.
- Priority per edge: rst > clear > flush > normal operation.
  - clear: all pointers and both sticky flags go to 0.
  - flush: all pointers go to 0; sticky flags are held.
  - Any write, read, commit or discard in the same cycle as clear or flush is ignored and sets no flags.
- Write: if wr_en and !full, then mem[wr_ptr] <= wr_data and wr_ptr++. If wr_en and full, the write is dropped and overflow is set to 1.
- Full is evaluated on the registered state; a same-cycle read does not make room for a write.
- Commit: cmt_ptr <= the post-write value of wr_ptr, so a word accepted in the same cycle becomes visible at the next edge.
- Discard: wr_ptr <= cmt_ptr; a same-cycle write is dropped with no overflow flag. Discard wins over commit if both are asserted.
- Read: if rd_en and !empty, rd_ptr++. If rd_en and empty, there is no change and underflow is set to 1. Reads never consume pending words.
- rd_data: combinational mem[rd_ptr[low bits]] when !empty, else 0. Latency from commit to visibility is 1 cycle; from pop to the next word is 1 cycle.
- Simultaneous rd_en and wr_en with commit: all three take effect in the same cycle. Occupancy changes by (+pending+write) - 1.
- Wrap-around: the pointers wrap past DEPTH without disturbing data order.
- A rst asserted mid-packet discards everything, committed or not.

Decomposition:
- Shared package usb_buf_pkg holds:
  - default constants BUF_DATA_W=8, BUF_DEPTH=64, BUF_AFULL=56;
  - typedef buf_status_t, a packed struct {empty, full, almost_full, overflow, underflow} used by the AHB status register.
- One sub-module, packet_fifo_mem: a DEPTH x DATA_W register array with one synchronous write port and one asynchronous read port. Pointer and flag logic stays in the top level.

Test Plan:
1. Reset, then write 0x00..0x3F (64 words) followed by commit → pending counts 1..64 and occupancy stays 0 during the writes; after commit, occupancy=64, full=1, almost_full=1, rd_data=0x00.
2. From a full buffer, pop 64 times → rd_data steps 0x01..0x3F then 0; occupancy reaches 0, empty=1, underflow stays 0. One extra rd_en → underflow=1 and occupancy stays 0.
3. Write 10 words (0xA0..0xA9), then assert discard together with wr_en=0xAA → pending=0, occupancy=0, empty=1, overflow=0. Next, write 3 words plus a commit on the third → occupancy=3.
4. Fill and commit 64 words, then write 0x55 → overflow=1 and occupancy=64. Assert flush → occupancy=0, pending=0, overflow remains 1. Assert clear → overflow=0.
5. Wrap: write/commit 40 words, pop 40, then write/commit 40 more (0x80..0xA7) → pops return 0x80..0xA7 in order; occupancy tracks correctly across the pointer wrap.
6. With 20 committed and 5 pending, assert rst for 1 cycle → every output returns to its reset value, rd_data=0. Also, a write at 55 total fill raises almost_full exactly when the fill reaches 56.
